// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//   Control FSM for the multi-cycle RV32I datapath. Each instruction is walked
//   through FETCH -> DECODE -> EXECUTE -> (MEM) -> WB. The FSM drives the
//   datapath enables, operand muxes and alu_op. It waits on instruction and
//   data memories that may stall.
//
// Parameters
//   TIMEOUT_CYCLES : wait cycles allowed in FETCH/MEM before a forced halt
//                    (0 = never time out)
//   COUNTER_WIDTH  : width of the performance counters
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   instruction                instruction memory data (valid with imem_ready)
//   imem_req / imem_ready      fetch handshake
//   dmem_req / dmem_we /
//   dmem_ready                 data access handshake (we=1 store)
//   pc_write, ir_write         pc <= pc+4, IR capture (both Mealy on fetch done)
//   reg_write, wb_sel          register file write enable / 1=load data
//   use_imm, imm_sel, alu_op   ALU operand and operation controls
//   state                      current state (FETCH=0 .. HALT=5)
//   illegal, timeout           sticky error flags
//   cycle_count, instret_count performance counters
//
// Build option
//   MCTRL_PERF_COUNTERS_EN : when defined, builds the cycle and instret
//   counters. Otherwise both counter ports are tied to zero.
// -----------------------------------------------------------------------------
module multicycle_control #(
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter int unsigned COUNTER_WIDTH  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              instruction,
    output logic                     imem_req,
    input  logic                     imem_ready,
    output logic                     dmem_req,
    output logic                     dmem_we,
    input  logic                     dmem_ready,
    output logic                     pc_write,
    output logic                     ir_write,
    output logic                     reg_write,
    output logic                     wb_sel,
    output logic                     use_imm,
    output logic                     imm_sel,
    output logic [2:0]               alu_op,
    output logic [2:0]               state,
    output logic                     illegal,
    output logic                     timeout,
    output logic [COUNTER_WIDTH-1:0] cycle_count,
    output logic [COUNTER_WIDTH-1:0] instret_count
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_HALT    = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        C_R     = 2'd0,
        C_I     = 2'd1,
        C_LOAD  = 2'd2,
        C_STORE = 2'd3
    } class_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLL = 3'd5;
    localparam logic [2:0] OP_SRL = 3'd6;
    localparam logic [2:0] OP_SLT = 3'd7;

    typedef struct packed {
        logic       ok;
        class_t     cls;
        logic [2:0] op;
    } dec_t;

    function automatic logic [2:0] f3_to_op(input logic [2:0] f3);
        logic [2:0] op;
        case (f3)
            3'b000:  op = OP_ADD;
            3'b111:  op = OP_AND;
            3'b110:  op = OP_OR;
            3'b100:  op = OP_XOR;
            3'b001:  op = OP_SLL;
            3'b101:  op = OP_SRL;
            3'b010:  op = OP_SLT;
            default: op = OP_ADD;
        endcase
        return op;
    endfunction

    function automatic dec_t decode(input logic [6:0] f7, input logic [2:0] f3,
                                    input logic [6:0] opc);
        dec_t d;
        d.ok  = 1'b0;
        d.cls = C_R;
        d.op  = OP_ADD;
        case (opc)
            7'b0110011: begin
                d.cls = C_R;
                if (f7 == 7'b0000000) begin
                    d.ok = (f3 != 3'b011);
                    d.op = f3_to_op(f3);
                end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                    d.ok = 1'b1;
                    d.op = OP_SUB;
                end
            end
            7'b0010011: begin
                d.cls = C_I;
                d.op  = f3_to_op(f3);
                case (f3)
                    3'b011:         d.ok = 1'b0;
                    // Shift-immediates only accept a zero upper immediate.
                    3'b001, 3'b101: d.ok = (f7 == 7'b0000000);
                    default:        d.ok = 1'b1;
                endcase
            end
            7'b0000011: begin
                d.cls = C_LOAD;
                d.ok  = (f3 == 3'b010);
            end
            7'b0100011: begin
                d.cls = C_STORE;
                d.ok  = (f3 == 3'b010);
            end
            default: ;
        endcase
        return d;
    endfunction

    state_t      state_q;
    class_t      cls_q;
    logic [4:0]  rd_q;
    logic [2:0]  op_q;
    logic        illegal_q;
    logic        timeout_q;
    logic [31:0] wait_q;
    // Only the fields the controller decodes: funct7, funct3, rd, opcode.
    logic [21:0] ir_q;
    dec_t        dec;
    logic        wait_hit;
    logic        is_mem_cls;
    logic        unused_fields;

    // rs1/rs2 (bits 24:15) belong to the datapath, not the controller.
    assign unused_fields = ^instruction[24:15];

    assign dec        = decode(ir_q[21:15], ir_q[14:12], ir_q[6:0]);
    assign is_mem_cls = (cls_q == C_LOAD) || (cls_q == C_STORE);
    // The wait counter reaching the limit on this stalled cycle forces a halt.
    assign wait_hit   = (TIMEOUT_CYCLES != 0) && ((wait_q + 32'd1) == TIMEOUT_CYCLES);

    always_ff @(posedge clk) begin
        if (state_q == S_FETCH && imem_ready) begin
            ir_q <= {instruction[31:25], instruction[14:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            cls_q     <= C_R;
            rd_q      <= 5'd0;
            op_q      <= OP_ADD;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            wait_q    <= 32'd0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem_ready) begin
                        state_q <= S_DECODE;
                        wait_q  <= 32'd0;
                    end else if (wait_hit) begin
                        state_q   <= S_HALT;
                        timeout_q <= 1'b1;
                        wait_q    <= 32'd0;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        wait_q <= wait_q + 32'd1;
                    end
                end
                S_DECODE: begin
                    cls_q <= dec.cls;
                    rd_q  <= ir_q[11:7];
                    op_q  <= dec.op;
                    if (dec.ok) begin
                        state_q <= S_EXECUTE;
                    end else begin
                        state_q   <= S_HALT;
                        illegal_q <= 1'b1;
                    end
                end
                S_EXECUTE: state_q <= is_mem_cls ? S_MEM : S_WB;
                S_MEM: begin
                    if (dmem_ready) begin
                        state_q <= (cls_q == C_LOAD) ? S_WB : S_FETCH;
                        wait_q  <= 32'd0;
                    end else if (wait_hit) begin
                        state_q   <= S_HALT;
                        timeout_q <= 1'b1;
                        wait_q    <= 32'd0;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        wait_q <= wait_q + 32'd1;
                    end
                end
                S_WB:    state_q <= S_FETCH;
                default: state_q <= S_HALT;
            endcase
        end
    end

    // Control outputs decode from the state; the ALU controls stay valid from
    // EXECUTE through MEM/WB so the address and result remain stable.
    always_comb begin
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        pc_write  = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        wb_sel    = 1'b0;
        use_imm   = 1'b0;
        imm_sel   = 1'b0;
        alu_op    = OP_ADD;
        if (state_q == S_EXECUTE || state_q == S_MEM || state_q == S_WB) begin
            alu_op  = op_q;
            use_imm = (cls_q != C_R);
            imm_sel = (cls_q == C_STORE);
        end
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                pc_write = imem_ready;
                ir_write = imem_ready;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (cls_q == C_STORE);
            end
            S_WB: begin
                reg_write = (rd_q != 5'd0);
                wb_sel    = (cls_q == C_LOAD);
            end
            default: ;
        endcase
    end

    assign state   = state_q;
    assign illegal = illegal_q;
    assign timeout = timeout_q;

`ifdef MCTRL_PERF_COUNTERS_EN
    logic [COUNTER_WIDTH-1:0] cyc_q;
    logic [COUNTER_WIDTH-1:0] ret_q;
    logic                     retire;

    // A store retires when its data access completes; everything else at WB.
    assign retire = (state_q == S_WB) ||
                    (state_q == S_MEM && dmem_ready && cls_q == C_STORE);

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            if (state_q != S_HALT) cyc_q <= cyc_q + {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
            if (retire)            ret_q <= ret_q + {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign cycle_count   = cyc_q;
    assign instret_count = ret_q;
`else
    assign cycle_count   = '0;
    assign instret_count = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
//   Self-checking bench for multicycle_control. Each instruction is expanded by
//   a transaction-level model into the per-cycle control vector it must
//   produce (given its fetch/memory wait counts). A compare process checks the
//   DUT against that vector every cycle. Literal checks pin reset values,
//   pulse counts, latencies, error flags and the performance counters.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

    localparam int TMO = 4;
    localparam int CW  = 32;

    localparam logic [2:0] S_F = 3'd0;
    localparam logic [2:0] S_D = 3'd1;
    localparam logic [2:0] S_E = 3'd2;
    localparam logic [2:0] S_M = 3'd3;
    localparam logic [2:0] S_W = 3'd4;
    localparam logic [2:0] S_H = 3'd5;

    localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_ILL = 4;

    localparam logic [31:0] I_ADD   = 32'h005303b3; // add  x7,x6,x5
    localparam logic [31:0] I_SUB   = 32'h40848533; // sub  x10,x9,x8
    localparam logic [31:0] I_ADDI  = 32'h00160693; // addi x13,x12,1
    localparam logic [31:0] I_XOR   = 32'h0021c233; // xor  x4,x3,x2
    localparam logic [31:0] I_ADDX0 = 32'h00208033; // add  x0,x1,x2
    localparam logic [31:0] I_SLLI  = 32'h00309093; // slli x1,x1,3
    localparam logic [31:0] I_LW    = 32'h00862703; // lw   x14,8(x12)
    localparam logic [31:0] I_SW    = 32'h00532223; // sw   x5,4(x6)
    localparam logic [31:0] I_SLTU  = 32'h001131b3; // sltu (unsupported)
    localparam logic [31:0] I_SRAI  = 32'h4030d093; // srai (unsupported)
    localparam logic [31:0] I_LB    = 32'h00860703; // lb   (unsupported)

    // Opcode match table: (ins & mask) == match selects the entry.
    localparam int NENT = 17;
    localparam logic [31:0] E_MASK [NENT] = '{
        32'hfe00707f, 32'hfe00707f, 32'hfe00707f, 32'hfe00707f, 32'hfe00707f,
        32'hfe00707f, 32'hfe00707f, 32'hfe00707f,
        32'h0000707f, 32'h0000707f, 32'h0000707f, 32'h0000707f, 32'h0000707f,
        32'hfe00707f, 32'hfe00707f,
        32'h0000707f, 32'h0000707f};
    localparam logic [31:0] E_MATCH [NENT] = '{
        32'h00000033, 32'h40000033, 32'h00001033, 32'h00002033, 32'h00004033,
        32'h00005033, 32'h00006033, 32'h00007033,
        32'h00000013, 32'h00002013, 32'h00004013, 32'h00006013, 32'h00007013,
        32'h00001013, 32'h00005013,
        32'h00002003, 32'h00002023};
    localparam int E_KIND [NENT] = '{
        K_R, K_R, K_R, K_R, K_R, K_R, K_R, K_R,
        K_I, K_I, K_I, K_I, K_I, K_I, K_I,
        K_LD, K_ST};
    localparam logic [2:0] E_OP [NENT] = '{
        3'd0, 3'd1, 3'd5, 3'd7, 3'd4, 3'd6, 3'd3, 3'd2,
        3'd0, 3'd7, 3'd4, 3'd3, 3'd2, 3'd5, 3'd6,
        3'd0, 3'd0};

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   instruction = 32'h0;
    logic          imem_ready = 1'b0;
    logic          dmem_ready = 1'b0;
    logic          imem_req, dmem_req, dmem_we, pc_write, ir_write, reg_write;
    logic          wb_sel, use_imm, imm_sel, illegal, timeout;
    logic [2:0]    alu_op, state;
    logic [CW-1:0] cycle_count, instret_count;

    always #5 clk = ~clk;

    multicycle_control #(.TIMEOUT_CYCLES(TMO), .COUNTER_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .instruction(instruction),
        .imem_req(imem_req), .imem_ready(imem_ready),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
        .wb_sel(wb_sel), .use_imm(use_imm), .imm_sel(imm_sel),
        .alu_op(alu_op), .state(state), .illegal(illegal), .timeout(timeout),
        .cycle_count(cycle_count), .instret_count(instret_count)
    );

    typedef struct packed {
        logic [2:0] st;
        logic       imem_req, dmem_req, dmem_we, pc_write, ir_write;
        logic       reg_write, wb_sel, use_imm, imm_sel;
        logic [2:0] alu_op;
        logic       illegal, timeout;
    } obs_t;

    obs_t got, exp_cur;
    logic exp_on = 1'b0;
    int   n_cmp = 0, n_fail = 0, cyc_no = 0;
    int   n_regw = 0, n_pcw = 0, n_irw = 0, n_dreq = 0, n_dwe = 0, n_wbsel = 0, n_busy = 0;
    logic m_ill = 1'b0, m_tmo = 1'b0;

    assign got = {state, imem_req, dmem_req, dmem_we, pc_write, ir_write,
                  reg_write, wb_sel, use_imm, imm_sel, alu_op, illegal, timeout};

    always @(negedge clk) begin
        if (exp_on) begin
            n_cmp++;
            if (got !== exp_cur) begin
                n_fail++;
                $display("FAIL cycle %0d controls: got %05h (state %0d) want %05h (state %0d)",
                         cyc_no, got, got.st, exp_cur, exp_cur.st);
            end
            if (got.reg_write) n_regw++;
            if (got.pc_write)  n_pcw++;
            if (got.ir_write)  n_irw++;
            if (got.dmem_req)  n_dreq++;
            if (got.dmem_we)   n_dwe++;
            if (got.wb_sel)    n_wbsel++;
            if (got.st != S_F) n_busy++;
        end
    end

    task automatic check(input string name, input logic [31:0] g, input logic [31:0] w);
        n_cmp++;
        if (g !== w) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, g, w);
        end
    endtask

    function automatic void model_decode(input logic [31:0] ins, output int kind,
                                         output logic [2:0] op);
        kind = K_ILL;
        op   = 3'd0;
        for (int i = 0; i < NENT; i++) begin
            if ((ins & E_MASK[i]) == E_MATCH[i]) begin
                kind = E_KIND[i];
                op   = E_OP[i];
            end
        end
    endfunction

    function automatic obs_t blank(input logic [2:0] st);
        obs_t e = '0;
        e.st       = st;
        e.imem_req = (st == S_F);
        e.illegal  = m_ill;
        e.timeout  = m_tmo;
        return e;
    endfunction

    task automatic cyc(input logic [31:0] ins, input logic ir, input logic dr,
                       input logic rst, input obs_t e);
        @(posedge clk);
        #1;
        reset       = rst;
        instruction = ins;
        imem_ready  = ir;
        dmem_ready  = dr;
        exp_cur     = e;
        exp_on      = 1'b1;
        cyc_no++;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_obs();
        n_regw = 0; n_pcw = 0; n_irw = 0; n_dreq = 0; n_dwe = 0; n_wbsel = 0; n_busy = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset      = 1'b1;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        exp_on     = 1'b0;
        m_ill      = 1'b0;
        m_tmo      = 1'b0;
    endtask

    task automatic halt_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(32'h0, 1'b1, 1'b1, 1'b0, blank(S_H));
    endtask

    // fw/mw: stalled cycles before fetch/data ready; rst_mem: MEM wait cycle
    // index on which reset is asserted (-1 for none).
    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                             input int rst_mem);
        int         kind;
        logic [2:0] op;
        obs_t       e;
        model_decode(ins, kind, op);
        for (int i = 0; i < fw && i < TMO; i++) cyc(32'hdeadbeef, 1'b0, 1'b1, 1'b0, blank(S_F));
        if (fw >= TMO) begin
            m_tmo = 1'b1;
            halt_cycles(2);
            return;
        end
        e = blank(S_F);
        e.pc_write = 1'b1;
        e.ir_write = 1'b1;
        cyc(ins, 1'b1, 1'b1, 1'b0, e);
        cyc(32'h0, 1'b1, 1'b1, 1'b0, blank(S_D));
        if (kind == K_ILL) begin
            m_ill = 1'b1;
            halt_cycles(3);
            return;
        end
        e = blank(S_E);
        e.alu_op  = op;
        e.use_imm = (kind != K_R);
        e.imm_sel = (kind == K_ST);
        cyc(32'h0, 1'b1, 1'b1, 1'b0, e);
        if (kind == K_LD || kind == K_ST) begin
            e.st       = S_M;
            e.dmem_req = 1'b1;
            e.dmem_we  = (kind == K_ST);
            for (int i = 0; i < mw && i < TMO; i++) begin
                if (i == rst_mem) begin
                    cyc(32'h0, 1'b1, 1'b0, 1'b1, e);
                    m_ill = 1'b0;
                    m_tmo = 1'b0;
                    cyc(32'h0, 1'b0, 1'b1, 1'b0, blank(S_F));
                    return;
                end
                cyc(32'h0, 1'b1, 1'b0, 1'b0, e);
            end
            if (mw >= TMO) begin
                m_tmo = 1'b1;
                halt_cycles(2);
                return;
            end
            cyc(32'h0, 1'b1, 1'b1, 1'b0, e);
            e.dmem_req = 1'b0;
            e.dmem_we  = 1'b0;
        end
        if (kind != K_ST) begin
            e.st        = S_W;
            e.reg_write = (ins[11:7] != 5'd0);
            e.wb_sel    = (kind == K_LD);
            cyc(32'h0, 1'b1, 1'b1, 1'b0, e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] ills [4];
        int          k;
        logic [2:0]  op;
        ills[0] = 32'h0; ills[1] = I_SLTU; ills[2] = I_SRAI; ills[3] = I_LB;

        // Zero-wait R/I sequence; counters are sampled after 12 cycles.
        do_reset();
        clear_obs();
        run_instr(I_ADD, 0, 0, -1);
        settle();
        check("add_reg_write_pulses", n_regw, 1);
        check("add_pc_write_pulses", n_pcw, 1);
        check("add_ir_write_pulses", n_irw, 1);
        check("add_busy_cycles", n_busy, 3);
        clear_obs();
        run_instr(I_SUB, 0, 0, -1);
        run_instr(I_ADDI, 0, 0, -1);
        cyc(32'h0, 1'b0, 1'b1, 1'b0, blank(S_F));
`ifdef MCTRL_PERF_COUNTERS_EN
        check("cycle_count_after_3", cycle_count, 12);
        check("instret_after_3", instret_count, 3);
`else
        check("cycle_count_tied", cycle_count, 0);
        check("instret_tied", instret_count, 0);
`endif
        settle();
        clear_obs();
        run_instr(I_SW, 0, 0, -1);
        settle();
        check("sw_reg_write_pulses", n_regw, 0);
        check("sw_dmem_we_cycles", n_dwe, 1);
        cyc(32'h0, 1'b0, 1'b1, 1'b0, blank(S_F));
`ifdef MCTRL_PERF_COUNTERS_EN
        check("cycle_count_after_sw", cycle_count, 17);
        check("instret_after_sw", instret_count, 4);
`else
        check("instret_tied_sw", instret_count, 0);
`endif

        // Stalls below the timeout limit, rd=0, shifts, stalled load/store.
        do_reset();
        run_instr(I_SUB, 3, 0, -1);
        run_instr(I_XOR, 0, 0, -1);
        settle();
        clear_obs();
        run_instr(I_ADDX0, 0, 0, -1);
        settle();
        check("rd0_reg_write_pulses", n_regw, 0);
        run_instr(I_SLLI, 0, 0, -1);
        settle();
        clear_obs();
        run_instr(I_LW, 0, 3, -1);
        settle();
        check("lw_dmem_req_cycles", n_dreq, 4);
        check("lw_busy_cycles", n_busy, 7);
        check("lw_wb_sel_cycles", n_wbsel, 1);
        clear_obs();
        run_instr(I_SW, 1, 1, -1);
        settle();
        check("sw_stall_dmem_we_cycles", n_dwe, 2);
        check("sw_stall_reg_write", n_regw, 0);

        // Illegal encodings halt with the sticky flag.
        for (int i = 0; i < 4; i++) begin
            do_reset();
            run_instr(ills[i], 0, 0, -1);
            settle();
            check($sformatf("illegal_flag_%0d", i), illegal, 1);
            check($sformatf("illegal_state_%0d", i), state, 5);
        end

        // Fetch and memory stalls hitting the limit.
        do_reset();
        run_instr(I_ADD, TMO, 0, -1);
        settle();
        check("fetch_timeout_flag", timeout, 1);
        check("fetch_timeout_state", state, 5);
        do_reset();
        run_instr(I_LW, 0, TMO, -1);
        settle();
        check("mem_timeout_flag", timeout, 1);
        check("mem_timeout_illegal", illegal, 0);

        // Reset while a load waits in MEM.
        do_reset();
        run_instr(I_LW, 0, 3, 2);
        settle();
        check("rst_mem_state", state, 0);
        check("rst_mem_dmem_req", dmem_req, 0);
        check("rst_mem_imem_req", imem_req, 1);

        // Pin the reference decoder itself.
        model_decode(I_SUB, k, op);
        check("model_sub_op", op, 1);
        model_decode(I_SRAI, k, op);
        check("model_srai_kind", k, K_ILL);
        model_decode(I_SW, k, op);
        check("model_sw_kind", k, K_ST);

        exp_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
